// File: rtl/seven_segment_pkg.sv
// Seven-segment pattern table shared by the display encoder and the readback decoder.
// Patterns are active-low, bit order gfedcba.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } seg_decode_t;

  // How stage 2 classifies the registered sample.
  typedef enum logic [2:0] {
    SK_IDLE,
    SK_BLANKING,
    SK_MULTI,
    SK_BAD,
    SK_GOOD
  } sample_kind_e;

  function automatic seg_decode_t decode_seg(input logic [6:0] seg);
    seg_decode_t r;
    r.valid = 1'b1;
    r.code  = 4'h0;
    case (seg)
      SEG_0:     r.code = 4'd0;
      SEG_1:     r.code = 4'd1;
      SEG_2:     r.code = 4'd2;
      SEG_3:     r.code = 4'd3;
      SEG_4:     r.code = 4'd4;
      SEG_5:     r.code = 4'd5;
      SEG_6:     r.code = 4'd6;
      SEG_7:     r.code = 4'd7;
      SEG_8:     r.code = 4'd8;
      SEG_9:     r.code = 4'd9;
      SEG_BLANK: r.code = CODE_BLANK;
      default:   r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // Inverse mapping for the display side; codes 10..14 show blank.
  function automatic logic [6:0] encode_code(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational seven-segment pattern to {valid, code} decoder.
module seven_segment_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_valid,
  output logic [3:0] o_code
);

  seg_decode_t w_dec;

  always_comb begin
    w_dec   = decode_seg(i_seg);
    o_valid = w_dec.valid;
    o_code  = w_dec.code;
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads back the multiplexed seven-segment bus, debounces each digit over several
// scans and invalidates digits that stop being refreshed.
module seven_segment_reader
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int STABLE_COUNT    = 3,
  parameter int TIMEOUT_SAMPLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     an_in,
  input  logic                      sample_en,
  output logic [4*NUM_DIGITS-1:0]   digits_out,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic                      value_valid,
  output logic                      value_update,
  output logic                      err
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_COUNT);
  localparam logic [7:0] AGE_MAX = 8'(TIMEOUT_SAMPLES);

  // sample_en is a strobe with no back-pressure: every cycle it is high, one
  // sample enters stage 1 and is processed by stage 2 on the following edge.
  logic                  r_s1_valid;
  logic [6:0]            r_s1_seg;
  logic [NUM_DIGITS-1:0] r_s1_an;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_seg   <= '0;
      r_s1_an    <= '0;
    end else begin
      r_s1_valid <= sample_en;
      if (sample_en) begin
        r_s1_seg <= seg_in;
        r_s1_an  <= an_in;
      end
    end
  end

  logic                  w_dec_valid;
  logic [3:0]            w_dec_code;
  logic [NUM_DIGITS-1:0] w_an_low;
  logic                  w_one_hot;
  sample_kind_e          w_kind;

  seven_segment_pattern_decode u_decode (
    .i_seg   (r_s1_seg),
    .o_valid (w_dec_valid),
    .o_code  (w_dec_code)
  );

  always_comb begin
    w_an_low  = ~r_s1_an;
    w_one_hot = (w_an_low != '0) &&
                ((w_an_low & (w_an_low - NUM_DIGITS'(1))) == '0);
    w_kind    = SK_IDLE;
    if (r_s1_valid) begin
      if (w_an_low == '0)   w_kind = SK_BLANKING;
      else if (!w_one_hot)  w_kind = SK_MULTI;
      else if (!w_dec_valid) w_kind = SK_BAD;
      else                  w_kind = SK_GOOD;
    end
  end

  logic [NUM_DIGITS-1:0] w_commit;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [3:0] r_cand;
    logic [3:0] r_cnt;
    logic [7:0] r_age;
    logic [3:0] r_code;
    logic       r_valid;

    logic [3:0] w_cand_nxt;
    logic [3:0] w_cnt_nxt;
    logic [7:0] w_age_nxt;
    logic       w_hit;
    logic       w_tick;
    logic       w_timeout;
    logic       w_commit_d;

    always_comb begin
      w_hit      = (w_kind == SK_GOOD) && w_an_low[i];
      // Blanking and bad-pattern samples age every digit; multi-anode ones are dropped.
      w_tick     = (w_kind == SK_BLANKING || w_kind == SK_BAD || w_kind == SK_GOOD) && !w_hit;
      w_cand_nxt = r_cand;
      w_cnt_nxt  = r_cnt;
      w_age_nxt  = r_age;
      w_timeout  = 1'b0;
      w_commit_d = 1'b0;

      if (w_hit) begin
        w_age_nxt = 8'd0;
        if (w_dec_code == r_cand) begin
          w_cnt_nxt = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + 4'd1;
        end else begin
          w_cand_nxt = w_dec_code;
          w_cnt_nxt  = 4'd1;
        end
        w_commit_d = (w_cnt_nxt >= CNT_MAX) && (!r_valid || r_code != w_dec_code);
      end else if (w_tick) begin
        if (w_kind == SK_BAD && w_an_low[i]) w_cnt_nxt = 4'd0;
        if (r_age < AGE_MAX) w_age_nxt = r_age + 8'd1;
        w_timeout = (w_age_nxt >= AGE_MAX);
        if (w_timeout) w_cnt_nxt = 4'd0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cand  <= 4'd0;
        r_cnt   <= 4'd0;
        r_age   <= 8'd0;
        r_code  <= 4'd0;
        r_valid <= 1'b0;
      end else begin
        r_cand <= w_cand_nxt;
        r_cnt  <= w_cnt_nxt;
        r_age  <= w_age_nxt;
        if (w_commit_d) begin
          r_code  <= w_dec_code;
          r_valid <= 1'b1;
        end else if (w_timeout) begin
          r_valid <= 1'b0;
        end
      end
    end

    assign w_commit[i]         = w_commit_d;
    assign digits_out[4*i +: 4] = r_code;
    assign digit_valid[i]      = r_valid;
  end

  logic r_err;
  logic r_update;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err    <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_err    <= (w_kind == SK_MULTI) || (w_kind == SK_BAD);
      r_update <= |w_commit;
    end
  end

  assign err          = r_err;
  assign value_update = r_update;
  assign value_valid  = &digit_valid;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: vector table, directed multi-cycle sequences and
// randomized traffic checked against a behavioural model.
module tb_seven_segment_reader;

  localparam int ND = 4;
  localparam int SC = 3;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic        sample_en;
  logic [15:0] digits_out;
  logic [3:0]  digit_valid;
  logic        value_valid;
  logic        value_update;
  logic        err;

  seven_segment_reader #(
    .NUM_DIGITS      (ND),
    .STABLE_COUNT    (SC),
    .TIMEOUT_SAMPLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .sample_en    (sample_en),
    .digits_out   (digits_out),
    .digit_valid  (digit_valid),
    .value_valid  (value_valid),
    .value_update (value_update),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int upd_seen = 0;

  logic [6:0] pat_tab[11];
  logic [3:0] code_tab[11];

  // Behavioural model state
  logic [3:0] m_cand[ND];
  int         m_cnt[ND];
  int         m_age[ND];
  logic [3:0] m_out[ND];
  logic       m_valid[ND];
  logic       m_p_valid;
  logic [6:0] m_p_seg;
  logic [3:0] m_p_an;
  logic       m_err;
  logic       m_upd;

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        en;
    logic [15:0] exp_dig;
    logic [3:0]  exp_val;
    logic        exp_upd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] lookup(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h0;
    for (int k = 0; k < 11; k++)
      if (pat_tab[k] == s) r = {1'b1, code_tab[k]};
    return r;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      m_cand[d] = 4'd0; m_cnt[d] = 0; m_age[d] = 0; m_out[d] = 4'd0; m_valid[d] = 1'b0;
    end
    m_p_valid = 1'b0; m_p_seg = 7'h0; m_p_an = 4'h0;
    m_err = 1'b0; m_upd = 1'b0;
  endfunction

  function automatic void model_sample(input logic [6:0] s, input logic [3:0] a);
    int         nlow;
    logic [4:0] lk;
    logic       ok;
    logic [3:0] c;
    logic       hit;
    nlow = $countones(~a);
    lk   = lookup(s);
    ok   = lk[4];
    c    = lk[3:0];
    if (nlow >= 2) begin
      m_err = 1'b1;
    end else begin
      if (nlow == 1 && !ok) m_err = 1'b1;
      for (int d = 0; d < ND; d++) begin
        hit = (nlow == 1) && !a[d] && ok;
        if (hit) begin
          if (c == m_cand[d]) m_cnt[d] = (m_cnt[d] < SC) ? m_cnt[d] + 1 : SC;
          else begin m_cand[d] = c; m_cnt[d] = 1; end
          m_age[d] = 0;
          if (m_cnt[d] >= SC && (!m_valid[d] || m_out[d] != c)) begin
            m_out[d] = c; m_valid[d] = 1'b1; m_upd = 1'b1;
          end
        end else begin
          if (nlow == 1 && !a[d]) m_cnt[d] = 0;
          if (m_age[d] < TO) m_age[d]++;
          if (m_age[d] >= TO) begin m_valid[d] = 1'b0; m_cnt[d] = 0; end
        end
      end
    end
  endfunction

  function automatic void model_edge(input logic [6:0] s, input logic [3:0] a,
                                     input logic e, input logic r);
    m_err = 1'b0;
    m_upd = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (m_p_valid) model_sample(m_p_seg, m_p_an);
      m_p_valid = e;
      if (e) begin m_p_seg = s; m_p_an = a; end
    end
  endfunction

  function automatic logic [15:0] m_digits();
    logic [15:0] v;
    for (int d = 0; d < ND; d++) v[4*d +: 4] = m_out[d];
    return v;
  endfunction

  function automatic logic [3:0] m_valids();
    logic [3:0] v;
    for (int d = 0; d < ND; d++) v[d] = m_valid[d];
    return v;
  endfunction

  // One clock: drive at the falling edge, then compare shortly after the rising edge.
  task automatic cycle(input logic [6:0] s, input logic [3:0] a, input logic e, input logic r);
    @(negedge clk);
    seg_in = s; an_in = a; sample_en = e; reset = r;
    @(posedge clk);
    #1;
    model_edge(s, a, e, r);
    check("model_digits", 32'(digits_out), 32'(m_digits()));
    check("model_valid", 32'(digit_valid), 32'(m_valids()));
    check("model_value_valid", 32'(value_valid), 32'(&m_valids()));
    check("model_update", 32'(value_update), 32'(m_upd));
    check("model_err", 32'(err), 32'(m_err));
    if (value_update) upd_seen++;
  endtask

  task automatic idle();
    cycle(7'h7F, 4'hF, 1'b0, 1'b0);
  endtask

  logic [6:0] round_pat[4];
  int         base;
  int         shown[ND];

  initial begin
    reset = 1'b1; sample_en = 1'b0; seg_in = 7'h7F; an_in = 4'hF;
    pat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};
    code_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'hF};
    model_reset();

    vecs[0]  = '{7'h24, 4'hE, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{7'h24, 4'hE, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0};
    vecs[2]  = '{7'h24, 4'hE, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0};
    vecs[3]  = '{7'h7F, 4'hF, 1'b0, 16'h0002, 4'h1, 1'b1, 1'b0};
    vecs[4]  = '{7'h7F, 4'hF, 1'b0, 16'h0002, 4'h1, 1'b0, 1'b0};
    vecs[5]  = '{7'h55, 4'hB, 1'b1, 16'h0002, 4'h1, 1'b0, 1'b0};
    vecs[6]  = '{7'h7F, 4'hF, 1'b0, 16'h0002, 4'h1, 1'b0, 1'b1};
    vecs[7]  = '{7'h24, 4'hC, 1'b1, 16'h0002, 4'h1, 1'b0, 1'b0};
    vecs[8]  = '{7'h7F, 4'hF, 1'b0, 16'h0002, 4'h1, 1'b0, 1'b1};
    vecs[9]  = '{7'h7F, 4'hF, 1'b1, 16'h0002, 4'h1, 1'b0, 1'b0};
    vecs[10] = '{7'h7F, 4'hF, 1'b0, 16'h0002, 4'h1, 1'b0, 1'b0};

    // Reset state
    cycle(7'h7F, 4'hF, 1'b0, 1'b1);
    cycle(7'h7F, 4'hF, 1'b0, 1'b1);
    check("reset_digits", 32'(digits_out), 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    check("reset_value_valid", 32'(value_valid), 32'h0);
    check("reset_update", 32'(value_update), 32'h0);
    check("reset_err", 32'(err), 32'h0);

    // Vector table: commit of digit 0, bad pattern, two anodes, blanking
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].seg, vecs[i].an, vecs[i].en, 1'b0);
      check("vec_digits", 32'(digits_out), 32'(vecs[i].exp_dig));
      check("vec_valid", 32'(digit_valid), 32'(vecs[i].exp_val));
      check("vec_update", 32'(value_update), 32'(vecs[i].exp_upd));
      check("vec_err", 32'(err), 32'(vecs[i].exp_err));
    end

    // Full scan showing 1,9,blank,0 for three rounds, then a fourth identical round
    round_pat = '{7'h79, 7'h10, 7'h7F, 7'h40};
    base = upd_seen;
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < ND; d++) cycle(round_pat[d], ~(4'b0001 << d), 1'b1, 1'b0);
    idle(); idle();
    check("scan_digits", 32'(digits_out), 32'h0F91);
    check("scan_value_valid", 32'(value_valid), 32'h1);
    check("scan_update_pulses", 32'(upd_seen - base), 32'd4);
    base = upd_seen;
    for (int d = 0; d < ND; d++) cycle(round_pat[d], ~(4'b0001 << d), 1'b1, 1'b0);
    idle(); idle();
    check("repeat_round_no_update", 32'(upd_seen - base), 32'd0);

    // Bad pattern on digit 2 restarts its stability count
    cycle(7'h55, 4'b1011, 1'b1, 1'b0);
    idle();
    check("bad_pattern_err", 32'(err), 32'h1);
    cycle(7'h19, 4'b1011, 1'b1, 1'b0);
    cycle(7'h19, 4'b1011, 1'b1, 1'b0);
    idle(); idle();
    check("two_samples_hold", 32'(digits_out[11:8]), 32'hF);
    cycle(7'h19, 4'b1011, 1'b1, 1'b0);
    idle();
    check("third_sample_update", 32'(value_update), 32'h1);
    check("third_sample_commit", 32'(digits_out[11:8]), 32'h4);

    // Staleness: only digit 0 refreshed
    base = upd_seen;
    for (int k = 0; k < 63; k++) cycle(7'h79, 4'b1110, 1'b1, 1'b0);
    idle();
    check("stale_before_timeout", 32'(digit_valid), 32'h5);
    cycle(7'h79, 4'b1110, 1'b1, 1'b0);
    idle();
    check("stale_at_timeout", 32'(digit_valid), 32'h1);
    check("stale_value_valid", 32'(value_valid), 32'h0);
    check("stale_digits_hold", 32'(digits_out[15:4]), 32'h049);
    check("stale_no_update", 32'(upd_seen - base), 32'd0);

    // Reset right after the strobe that would commit digit 1
    cycle(7'h24, 4'b1101, 1'b1, 1'b0);
    cycle(7'h24, 4'b1101, 1'b1, 1'b0);
    cycle(7'h24, 4'b1101, 1'b1, 1'b0);
    cycle(7'h7F, 4'hF, 1'b0, 1'b1);
    check("midreset_digits", 32'(digits_out), 32'h0);
    check("midreset_valid", 32'(digit_valid), 32'h0);
    check("midreset_update", 32'(value_update), 32'h0);
    base = upd_seen;
    idle(); idle(); idle();
    check("midreset_no_pulse", 32'(upd_seen - base), 32'd0);

    // Randomized traffic against the model
    for (int d = 0; d < ND; d++) shown[d] = $urandom_range(0, 10);
    for (int i = 0; i < 4000; i++) begin
      logic [6:0] s;
      logic [3:0] a;
      logic       e;
      logic       r;
      int         k;
      int         dsel;
      int         dmax;
      dmax = ((i / 400) % 2 == 1) ? 1 : ND - 1;
      r = ($urandom_range(0, 999) == 0);
      e = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 19);
      dsel = $urandom_range(0, dmax);
      if ($urandom_range(0, 39) == 0) shown[dsel] = $urandom_range(0, 10);
      if (k < 15) begin
        a = ~(4'b0001 << dsel);
        s = pat_tab[shown[dsel]];
      end else if (k < 17) begin
        a = ~(4'b0001 << dsel);
        s = 7'($urandom_range(0, 127));
      end else if (k == 17) begin
        a = 4'hF;
        s = 7'($urandom_range(0, 127));
      end else begin
        a = ~(4'b0011 << $urandom_range(0, 2));
        s = pat_tab[shown[dsel]];
      end
      cycle(s, a, e, r);
    end
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
